// File: rtl/uart_pwm_pkg.sv
// ============================================================================
//  Module   : uart_pwm_pkg
//  Purpose  : Shared types and constants for the UART-controlled LED PWM driver
//  Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pwm_pkg;

    typedef enum logic [0:0] {
        P_CHAN = 1'b0,
        P_DUTY = 1'b1
    } parser_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0] ACK_OK  = 8'h4B;
    localparam logic [7:0] ACK_ERR = 8'h45;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

endpackage

`default_nettype wire

// File: rtl/uart_byte_rx.sv
// ============================================================================
//  Module   : uart_byte_rx
//  Purpose  : 8N1 UART byte receiver with input synchroniser, byte-valid and
//             framing-error pulses
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_byte_rx
    import uart_pwm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       pll_clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int             c_cw        = $clog2(CLKS_PER_BIT);
    localparam logic [c_cw-1:0] c_one      = c_cw'(1);
    localparam logic [c_cw-1:0] c_bit_last = c_cw'(CLKS_PER_BIT - 1);
    localparam logic [c_cw-1:0] c_half_last = c_cw'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]     c_last_data = 3'(UART_DATA_BITS - 1);

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       state_q, state_d;
    logic [c_cw-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + c_one;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // A line back high at mid-start-bit is treated as a glitch
                if (cnt_q == c_half_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == c_bit_last) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == c_last_data) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == c_bit_last) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = rx_sync_q;
                    ferr_d  = !rx_sync_q;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

`default_nettype wire

// File: rtl/uart_pwm_leds.sv
// ============================================================================
//  Module   : uart_pwm_leds
//  Purpose  : UART-commanded N-channel LED PWM driver; {chan, duty} commands,
//             optional 'K'/'E' acknowledge on TX when UART_PWM_ACK_EN is defined
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_pwm_leds
    import uart_pwm_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 104,
    parameter int N_CH           = 3,
    parameter int PWM_BITS       = 8,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic            pll_clk,
    input  logic            rst_n,
    input  logic            uart_rx_i,
    output logic            uart_tx_o,
    output logic [N_CH-1:0] led_o
);

    localparam logic                c_led_off = 1'(LED_ACTIVE_LOW);
    localparam logic [PWM_BITS-1:0] c_cnt_one = PWM_BITS'(1);

    // Reset asserts asynchronously but releases on a clock edge
    logic rst_ff1_q, rst_ff2_q, rst_int_n;

    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_ff1_q <= 1'b0;
            rst_ff2_q <= 1'b0;
        end else begin
            rst_ff1_q <= 1'b1;
            rst_ff2_q <= rst_ff1_q;
        end
    end

    assign rst_int_n = rst_ff2_q;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    uart_byte_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .pll_clk      (pll_clk),
        .rst_n        (rst_int_n),
        .rx_i         (uart_rx_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_ferr)
    );

    parser_state_t       pstate_q, pstate_d;
    logic [7:0]          chan_q, chan_d;
    logic [PWM_BITS-1:0] pend_q [N_CH];
    logic [PWM_BITS-1:0] pend_d [N_CH];
    logic [PWM_BITS-1:0] act_q  [N_CH];
    logic [PWM_BITS-1:0] act_d  [N_CH];
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]     led_q, led_d;
    logic [PWM_BITS-1:0] duty_w;
    logic                ack_req;
    logic [7:0]          ack_byte;

    assign duty_w = PWM_BITS'(rx_byte);

    always_ff @(posedge pll_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pstate_q <= P_CHAN;
            chan_q   <= '0;
            cnt_q    <= '0;
            led_q    <= {N_CH{c_led_off}};
            for (int i = 0; i < N_CH; i++) begin
                pend_q[i] <= '0;
                act_q[i]  <= '0;
            end
        end else begin
            pstate_q <= pstate_d;
            chan_q   <= chan_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
            for (int i = 0; i < N_CH; i++) begin
                pend_q[i] <= pend_d[i];
                act_q[i]  <= act_d[i];
            end
        end
    end

    always_comb begin
        pstate_d = pstate_q;
        chan_d   = chan_q;
        pend_d   = pend_q;
        ack_req  = 1'b0;
        ack_byte = ACK_ERR;
        if (rx_ferr) begin
            pstate_d = P_CHAN;
        end else if (rx_valid) begin
            case (pstate_q)
                P_CHAN: begin
                    chan_d   = rx_byte;
                    pstate_d = P_DUTY;
                end
                P_DUTY: begin
                    pstate_d = P_CHAN;
                    ack_req  = 1'b1;
                    if (chan_q < 8'(N_CH)) begin
                        ack_byte = ACK_OK;
                        for (int i = 0; i < N_CH; i++) begin
                            if (chan_q == 8'(i)) begin
                                pend_d[i] = duty_w;
                            end
                        end
                    end
                end
                default: begin
                    pstate_d = P_CHAN;
                end
            endcase
        end
    end

    // The compare uses the value act is about to take, so the wrap cycle
    // already reflects the newly latched duty.
    always_comb begin
        cnt_d = cnt_q + c_cnt_one;
        led_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            act_d[i] = (cnt_q == '0) ? pend_q[i] : act_q[i];
            led_d[i] = (cnt_q < act_d[i]) ^ c_led_off;
        end
    end

    assign led_o = led_q;

`ifdef UART_PWM_ACK_EN
    localparam int             c_cw       = $clog2(CLKS_PER_BIT);
    localparam logic [c_cw-1:0] c_one      = c_cw'(1);
    localparam logic [c_cw-1:0] c_bit_last = c_cw'(CLKS_PER_BIT - 1);

    logic            tx_busy_q, tx_busy_d;
    logic            tx_line_q, tx_line_d;
    logic [8:0]      tx_shift_q, tx_shift_d;
    logic [c_cw-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;

    always_ff @(posedge pll_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            tx_busy_q  <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_shift_q <= '1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
        end else begin
            tx_busy_q  <= tx_busy_d;
            tx_line_q  <= tx_line_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
        end
    end

    // tx_bit_q counts completed bit periods; period 9 is the stop bit
    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_line_d  = tx_line_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        if (tx_busy_q) begin
            if (tx_cnt_q == c_bit_last) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                    tx_line_d = 1'b1;
                end else begin
                    tx_line_d  = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[8:1]};
                    tx_bit_d   = tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + c_one;
            end
        end else if (ack_req) begin
            tx_busy_d  = 1'b1;
            tx_line_d  = 1'b0;
            tx_shift_d = {1'b1, ack_byte};
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
        end
    end

    assign uart_tx_o = tx_line_q;
`else
    logic unused_ack;
    assign unused_ack = ^{ack_req, ack_byte};
    assign uart_tx_o  = 1'b1;
`endif

endmodule

`default_nettype wire
